// File: rtl/riscv_pkg.sv
// Shared register-file definitions for the integer pipeline write-back path.
package riscv_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_DW = 32;

  localparam logic [REG_AW-1:0] X0_ADDR = '0;

  typedef struct packed {
    logic [REG_AW-1:0] waddr;
    logic [REG_DW-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result FIFO: power-of-two depth, naturally wrapping pointers.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = $bits(wb_entry_t)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regs_wb_ctrl.sv
// Register-file write-port arbiter (EX over FIFO) with pending-write scoreboard.
// Optional WB_BYPASS_EN: LSU result skips an empty FIFO when EX is idle.
module regs_wb_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = REG_AW,
  parameter int unsigned DW    = REG_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_wen_i,
  input  logic [AW-1:0] ex_waddr_i,
  input  logic [DW-1:0] ex_wdata_i,
  input  logic          lsu_valid_i,
  output logic          lsu_ready_o,
  input  logic [AW-1:0] lsu_waddr_i,
  input  logic [DW-1:0] lsu_wdata_i,
  input  logic          issue_valid_i,
  input  logic [AW-1:0] issue_rd_i,
  output logic [31:0]   busy_o,
  output logic [AW-1:0] reg_waddr_o,
  output logic [DW-1:0] reg_wdata_o,
  output logic          reg_wen_o
);

  localparam int unsigned EW = AW + DW;

  logic                    ex_sel;
  logic                    bypass;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [$clog2(DEPTH):0]  count;
  logic [EW-1:0]           head;
  logic [AW-1:0]           head_waddr;
  logic [DW-1:0]           head_wdata;
  logic [31:0]             busy_q;
  logic [31:0]             busy_next;

  assign ex_sel      = ex_wen_i && (ex_waddr_i != AW'(X0_ADDR));
  assign lsu_ready_o = (count != ($clog2(DEPTH)+1)'(DEPTH));
  assign pop         = !ex_sel && !empty;
  assign head_waddr  = head[EW-1:DW];
  assign head_wdata  = head[DW-1:0];

`ifdef WB_BYPASS_EN
  assign bypass = !ex_sel && empty && lsu_valid_i;
`else
  assign bypass = 1'b0;
`endif

  assign push = lsu_valid_i && !full && !bypass;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({lsu_waddr_i, lsu_wdata_i}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Clear before set so an issue to a register retiring this cycle stays busy.
  always_comb begin
    busy_next = busy_q;
    if (pop) begin
      busy_next[head_waddr] = 1'b0;
    end
    if (bypass) begin
      busy_next[lsu_waddr_i] = 1'b0;
    end
    if (issue_valid_i && (issue_rd_i != AW'(X0_ADDR))) begin
      busy_next[issue_rd_i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wen_o   <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
      busy_q      <= '0;
    end else begin
      busy_q    <= busy_next;
      reg_wen_o <= 1'b0;
      if (ex_sel) begin
        reg_wen_o   <= 1'b1;
        reg_waddr_o <= ex_waddr_i;
        reg_wdata_o <= ex_wdata_i;
      end else if (pop) begin
        reg_wen_o   <= (head_waddr != AW'(X0_ADDR));
        reg_waddr_o <= head_waddr;
        reg_wdata_o <= head_wdata;
      end else if (bypass) begin
        reg_wen_o   <= (lsu_waddr_i != AW'(X0_ADDR));
        reg_waddr_o <= lsu_waddr_i;
        reg_wdata_o <= lsu_wdata_i;
      end
    end
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_regs_wb_ctrl.sv
// Self-checking bench for regs_wb_ctrl: queue-based reference model plus directed literals.
module tb_regs_wb_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_wen_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic [31:0] busy_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        reg_wen_o;

  regs_wb_ctrl #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_wen_i      (ex_wen_i),
    .ex_waddr_i    (ex_waddr_i),
    .ex_wdata_i    (ex_wdata_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_ready_o   (lsu_ready_o),
    .lsu_waddr_i   (lsu_waddr_i),
    .lsu_wdata_i   (lsu_wdata_i),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .busy_o        (busy_o),
    .reg_waddr_o   (reg_waddr_o),
    .reg_wdata_o   (reg_wdata_o),
    .reg_wen_o     (reg_wen_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_busy;
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_wen", {31'd0, reg_wen_o}, {31'd0, m_wen});
      if (m_wen) begin
        check("model_waddr", {27'd0, reg_waddr_o}, {27'd0, m_addr});
        check("model_wdata", reg_wdata_o, m_data);
      end
      check("model_busy", busy_o, m_busy);
      check("model_ready", {31'd0, lsu_ready_o}, {31'd0, (q.size() != DEPTH)});
    end
  end

  task automatic drive(input bit exw, input logic [4:0] exa, input logic [31:0] exd,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit iv, input logic [4:0] ir);
    ex_wen_i = exw; ex_waddr_i = exa; ex_wdata_i = exd;
    lsu_valid_i = lsu_valid_i; lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
    issue_valid_i = iv; issue_rd_i = ir;
  endtask

  task automatic idle();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
  endtask

  // One clock: capture the inputs, advance the model on the edge, return 1 time unit later.
  task automatic tick();
    bit          r, exw, lv, iv, ready, byp;
    logic [4:0]  exa, la, ir;
    logic [31:0] exd, ld;
    int          clr;
    ent_t        e;
    r = rst; exw = ex_wen_i; exa = ex_waddr_i; exd = ex_wdata_i;
    lv = lsu_valid_i; la = lsu_waddr_i; ld = lsu_wdata_i;
    iv = issue_valid_i; ir = issue_rd_i;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_busy = 32'd0; m_wen = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    end else begin
      ready = (q.size() < DEPTH);
      clr = -1;
      byp = 1'b0;
      m_wen = 1'b0;
      if (exw && exa != 5'd0) begin
        m_wen = 1'b1; m_addr = exa; m_data = exd;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_wen = (e.a != 5'd0); m_addr = e.a; m_data = e.d; clr = int'(e.a);
      end
`ifdef WB_BYPASS_EN
      else if (lv) begin
        byp = 1'b1;
        m_wen = (la != 5'd0); m_addr = la; m_data = ld; clr = int'(la);
      end
`endif
      if (lv && ready && !byp) begin
        e.a = la; e.d = ld;
        q.push_back(e);
      end
      if (clr > 0) m_busy[clr] = 1'b0;
      if (iv && ir != 5'd0) m_busy[ir] = 1'b1;
    end
    #1;
  endtask

  initial begin
    bit          exw, lv, iv;
    logic [4:0]  exa;
    rst = 1'b1;
    lsu_valid_i = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_wen", {31'd0, reg_wen_o}, 32'd0);
    check("rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
    check("rst_wdata", reg_wdata_o, 32'd0);
    check("rst_busy", busy_o, 32'd0);
    check("rst_ready", {31'd0, lsu_ready_o}, 32'd1);

    // EX single-cycle write
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0);
    tick();
    check("ex_wen", {31'd0, reg_wen_o}, 32'd1);
    check("ex_waddr", {27'd0, reg_waddr_o}, 32'd5);
    check("ex_wdata", reg_wdata_o, 32'hDEADBEEF);
    idle();
    tick();
    check("ex_wen_drop", {31'd0, reg_wen_o}, 32'd0);

    // Long-latency write clears its busy bit when written
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7);
    tick();
    idle();
    tick();
    tick();
    check("lsu_busy_set", busy_o, 32'h0000_0080);
    drive(0, 5'd0, 32'd0, 1, 5'd7, 32'h1234, 0, 5'd0);
    tick();
`ifndef WB_BYPASS_EN
    check("lsu_busy_hold", {31'd0, busy_o[7]}, 32'd1);
    check("lsu_wen_wait", {31'd0, reg_wen_o}, 32'd0);
    idle();
    tick();
`else
    idle();
`endif
    check("lsu_wen", {31'd0, reg_wen_o}, 32'd1);
    check("lsu_waddr", {27'd0, reg_waddr_o}, 32'd7);
    check("lsu_wdata", reg_wdata_o, 32'h1234);
    check("lsu_busy_clr", {31'd0, busy_o[7]}, 32'd0);
    tick();

    // Fill the FIFO under EX pressure, then drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(i), 32'(i), 1, 5'(10 + i), 32'hA0 + 32'(i), 0, 5'd0);
      tick();
    end
    check("fill_ready", {31'd0, lsu_ready_o}, 32'd0);
    idle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("drain_wen", {31'd0, reg_wen_o}, 32'd1);
      check("drain_waddr", {27'd0, reg_waddr_o}, 32'(10 + i));
      check("drain_wdata", reg_wdata_o, 32'hA0 + 32'(i));
      if (i == 1) check("drain_ready", {31'd0, lsu_ready_o}, 32'd1);
    end
    tick();

    // x0 writes from both sources
    drive(1, 5'd0, 32'h55, 1, 5'd0, 32'h66, 0, 5'd0);
    tick();
    check("x0_wen", {31'd0, reg_wen_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd1, 32'h10, 1, 5'd0, 32'h77, 1, 5'd0);
      tick();
    end
    check("x0_full", {31'd0, lsu_ready_o}, 32'd0);
    idle();
    tick();
    check("x0_pop_wen", {31'd0, reg_wen_o}, 32'd0);
    check("x0_pop_ready", {31'd0, lsu_ready_o}, 32'd1);
    check("x0_busy0", {31'd0, busy_o[0]}, 32'd0);
    repeat (4) tick();

    // Set wins over same-cycle clear
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9);
    tick();
    drive(1, 5'd3, 32'h33, 1, 5'd9, 32'h99, 0, 5'd0);
    tick();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9);
    tick();
    check("setwin_wen", {31'd0, reg_wen_o}, 32'd1);
    check("setwin_waddr", {27'd0, reg_waddr_o}, 32'd9);
    check("setwin_busy", {31'd0, busy_o[9]}, 32'd1);
    idle();
    tick();

    // Reset mid-operation
    for (int i = 8; i <= 11; i++) begin
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'(i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd1, 32'h1, 1, 5'(8 + i), 32'hB0 + 32'(i), 0, 5'd0);
      tick();
    end
    check("pre_rst_busy", busy_o, 32'h0000_0F00);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", busy_o, 32'd0);
    check("mid_rst_ready", {31'd0, lsu_ready_o}, 32'd1);
    check("mid_rst_wen", {31'd0, reg_wen_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_wen", {31'd0, reg_wen_o}, 32'd0);
    end

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      exw = ($urandom_range(0, 99) < 50);
      exa = 5'($urandom_range(0, 15));
      if (m_busy[exa]) exw = 1'b0;
      lv = ($urandom_range(0, 99) < 40);
      iv = ($urandom_range(0, 99) < 25);
      drive(exw, exa, $urandom, lv, 5'($urandom_range(0, 15)), $urandom,
            iv, 5'($urandom_range(0, 15)));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
